layer_priority_mixer: RTL and testbench

LAYER_PRIORITY_MIXER -- requirements
Module: layer_priority_mixer

---
 rtl/layer_priority_mixer.sv | 144 ++++++++++++++
 tb/tb_layer_priority_mixer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/layer_priority_mixer.sv
// Two-stage priority compositor for N_LAYERS RGB planes with colour keying,
// frame-synchronous layer masks and per-frame layer-0 collision reporting.
module layer_priority_mixer #(
    parameter int              N_LAYERS = 6,
    parameter int              RGB_W    = 12,
    parameter bit              KEY_EN   = 1'b1,
    parameter logic [RGB_W-1:0] KEY_RGB = 12'hF0F
) (
    input  logic                      sys_clk,
    input  logic                      Reset,
    input  logic                      pix_valid,
    input  logic                      video_on,
    input  logic                      frame_start,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]       layer_en,
    input  logic [RGB_W-1:0]          bg_rgb,
    input  logic [N_LAYERS-1:0]       mask_in,
    input  logic                      mask_wr,
    output logic [RGB_W-1:0]          rgb_out,
    output logic                      rgb_valid,
    output logic [N_LAYERS-2:0]       collision,
    output logic                      collision_valid
);

    // Mask state
    logic [N_LAYERS-1:0] pending_mask_reg;
    logic [N_LAYERS-1:0] active_mask_reg;

    // Stage 1 state
    logic                      s1_valid_reg;
    logic [N_LAYERS-1:0]       s1_vis_reg;
    logic                      s1_video_reg;
    logic [N_LAYERS*RGB_W-1:0] s1_rgb_reg;
    logic [RGB_W-1:0]          s1_bg_reg;

    // Stage 2 / output state
    logic [RGB_W-1:0]    rgb_out_reg;
    logic                rgb_valid_reg;
    logic [N_LAYERS-2:0] sticky_reg;
    logic [N_LAYERS-2:0] collision_reg;
    logic                collision_valid_reg;

    logic [N_LAYERS-1:0] vis_next;
    logic [N_LAYERS-2:0] hit_next;
    logic [RGB_W-1:0]    sel_rgb;

    // Visibility uses the mask in force before any same-cycle frame_start update.
    genvar gi;
    generate
        for (gi = 0; gi < N_LAYERS; gi++) begin : g_vis
            logic keyed;
            assign keyed        = KEY_EN && (layer_rgb[gi*RGB_W +: RGB_W] == KEY_RGB);
            assign vis_next[gi] = layer_en[gi] & active_mask_reg[gi] & ~keyed;
        end
        for (gi = 1; gi < N_LAYERS; gi++) begin : g_hit
            assign hit_next[gi-1] = pix_valid & video_on & vis_next[0] & vis_next[gi];
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            pending_mask_reg <= '1;
            active_mask_reg  <= '1;
        end else begin
            if (mask_wr) begin
                pending_mask_reg <= mask_in;
            end
            if (frame_start) begin
                active_mask_reg <= mask_wr ? mask_in : pending_mask_reg;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            s1_valid_reg <= 1'b0;
            s1_vis_reg   <= '0;
            s1_video_reg <= 1'b0;
        end else begin
            s1_valid_reg <= pix_valid;
            if (pix_valid) begin
                s1_vis_reg   <= vis_next;
                s1_video_reg <= video_on;
            end
        end
    end

    // Colour data needs no reset: it is only observed behind s1_valid_reg.
    always_ff @(posedge sys_clk) begin
        if (pix_valid) begin
            s1_rgb_reg <= layer_rgb;
            s1_bg_reg  <= bg_rgb;
        end
    end

    // Walk from lowest priority upward so the lowest visible index wins.
    always_comb begin
        sel_rgb = s1_bg_reg;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (s1_vis_reg[k]) begin
                sel_rgb = s1_rgb_reg[k*RGB_W +: RGB_W];
            end
        end
        if (!s1_video_reg) begin
            sel_rgb = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            rgb_out_reg   <= '0;
            rgb_valid_reg <= 1'b0;
        end else begin
            rgb_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                rgb_out_reg <= sel_rgb;
            end
        end
    end

    // A hit in the frame_start cycle still belongs to the closing frame.
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            sticky_reg          <= '0;
            collision_reg       <= '0;
            collision_valid_reg <= 1'b0;
        end else begin
            if (frame_start) begin
                collision_reg       <= sticky_reg | hit_next;
                sticky_reg          <= '0;
                collision_valid_reg <= 1'b1;
            end else begin
                sticky_reg          <= sticky_reg | hit_next;
                collision_valid_reg <= 1'b0;
            end
        end
    end

    assign rgb_out         = rgb_out_reg;
    assign rgb_valid       = rgb_valid_reg;
    assign collision       = collision_reg;
    assign collision_valid = collision_valid_reg;

endmodule

// File: tb/tb_layer_priority_mixer.sv
// Directed bench for layer_priority_mixer: priority, keying, mask timing,
// collision reporting, streaming and mid-pipeline reset.
module tb_layer_priority_mixer;

    localparam int NL = 6;
    localparam int W  = 12;

    logic            sys_clk = 1'b0;
    logic            Reset = 1'b1;
    logic            pix_valid = 1'b0;
    logic            video_on = 1'b1;
    logic            frame_start = 1'b0;
    logic [NL*W-1:0] layer_rgb;
    logic [NL-1:0]   layer_en = '0;
    logic [W-1:0]    bg_rgb = 12'h123;
    logic [NL-1:0]   mask_in = '1;
    logic            mask_wr = 1'b0;
    logic [W-1:0]    rgb_out;
    logic            rgb_valid;
    logic [NL-2:0]   collision;
    logic            collision_valid;

    logic [W-1:0] lay [NL];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    always_comb begin
        layer_rgb = '0;
        for (int k = 0; k < NL; k++) layer_rgb[k*W +: W] = lay[k];
    end

    layer_priority_mixer #(.N_LAYERS(NL), .RGB_W(W), .KEY_EN(1'b1), .KEY_RGB(12'hF0F)) dut (
        .sys_clk(sys_clk), .Reset(Reset), .pix_valid(pix_valid), .video_on(video_on),
        .frame_start(frame_start), .layer_rgb(layer_rgb), .layer_en(layer_en),
        .bg_rgb(bg_rgb), .mask_in(mask_in), .mask_wr(mask_wr), .rgb_out(rgb_out),
        .rgb_valid(rgb_valid), .collision(collision), .collision_valid(collision_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One pixel strobe; checks the 2-cycle latency and the resulting colour.
    task automatic run_pixel(input string tag, input logic [NL-1:0] en, input logic vid,
                             input logic fs, input logic [W-1:0] exp);
        layer_en = en; video_on = vid; frame_start = fs; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0; frame_start = 1'b0; layer_en = '0; video_on = 1'b1;
        check({tag, "_t1_valid"}, rgb_valid, 0);
        tick();
        check({tag, "_t2_valid"}, rgb_valid, 1);
        check(tag, rgb_out, exp);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic write_mask(input logic [NL-1:0] m, input logic fs);
        mask_in = m; mask_wr = 1'b1; frame_start = fs;
        tick();
        mask_wr = 1'b0; frame_start = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NL; k++) lay[k] = 12'h000;
        tick();
        check("rst_rgb_out", rgb_out, 0);
        check("rst_rgb_valid", rgb_valid, 0);
        check("rst_collision", collision, 0);
        check("rst_collision_valid", collision_valid, 0);
        check("rst_active_mask", dut.active_mask_reg, 6'h3F);
        check("rst_pending_mask", dut.pending_mask_reg, 6'h3F);
        Reset = 1'b0;
        tick();

        // Priority and keying
        lay[0] = 12'hFFF; lay[1] = 12'h0F0; lay[2] = 12'h00F; lay[5] = 12'h0AB;
        run_pixel("prio_100110", 6'b100110, 1'b1, 1'b0, 12'h0F0);
        tick();
        check("hold_valid_low", rgb_valid, 0);
        check("hold_rgb_out", rgb_out, 12'h0F0);
        lay[0] = 12'hF00;
        run_pixel("no_black_conflict", 6'b000011, 1'b1, 1'b0, 12'hF00);
        lay[3] = 12'hF0F;
        run_pixel("key_to_bg", 6'b001000, 1'b1, 1'b0, 12'h123);
        run_pixel("key_video_off", 6'b001000, 1'b0, 1'b0, 12'h000);
        run_pixel("none_enabled_bg", 6'b000000, 1'b1, 1'b0, 12'h123);
        run_pixel("key_falls_through", 6'b001100, 1'b1, 1'b0, 12'h00F);
        lay[0] = 12'hF0F;
        run_pixel("key_on_layer0", 6'b000011, 1'b1, 1'b0, 12'h0F0);

        // Mask timing
        lay[0] = 12'hFFF; lay[1] = 12'hA00;
        write_mask(6'b111110, 1'b0);
        run_pixel("mask_pending_midframe", 6'b000011, 1'b1, 1'b0, 12'hFFF);
        pulse_frame();
        run_pixel("mask_after_frame", 6'b000011, 1'b1, 1'b0, 12'hA00);
        write_mask(6'b111111, 1'b0);
        run_pixel("fs_pixel_old_mask", 6'b000011, 1'b1, 1'b1, 12'hA00);
        run_pixel("fs_pixel_new_mask", 6'b000011, 1'b1, 1'b0, 12'hFFF);
        write_mask(6'b111101, 1'b1);
        check("wr_fs_active", dut.active_mask_reg, 6'b111101);
        check("wr_fs_pending", dut.pending_mask_reg, 6'b111101);
        run_pixel("wr_fs_l0", 6'b000011, 1'b1, 1'b0, 12'hFFF);
        run_pixel("wr_fs_l1_masked", 6'b000010, 1'b1, 1'b0, 12'h123);

        // Collision reporting
        write_mask(6'b111111, 1'b1);
        check("clear_cv_pulse", collision_valid, 1);
        tick();
        check("clear_cv_low", collision_valid, 0);
        lay[0] = 12'h111; lay[2] = 12'h222; lay[4] = 12'h444; lay[5] = 12'h555;
        run_pixel("coll_px_0_4", 6'b010001, 1'b1, 1'b0, 12'h111);
        run_pixel("coll_px_0_2", 6'b000101, 1'b1, 1'b0, 12'h111);
        pulse_frame();
        check("coll_valid", collision_valid, 1);
        check("coll_value", collision, 5'b01010);
        tick();
        check("coll_valid_once", collision_valid, 0);
        check("coll_hold", collision, 5'b01010);
        run_pixel("coll_video_off", 6'b000011, 1'b0, 1'b0, 12'h000);
        run_pixel("coll_l0_only", 6'b000001, 1'b1, 1'b0, 12'h111);
        pulse_frame();
        check("coll_empty_valid", collision_valid, 1);
        check("coll_empty_value", collision, 5'b00000);
        run_pixel("coll_same_cycle_px", 6'b100001, 1'b1, 1'b1, 12'h111);
        check("coll_same_cycle", collision, 5'b10000);
        check("coll_same_cycle_cv", collision_valid, 0);

        // Streaming 8 pixels back to back
        write_mask(6'b111110, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                lay[0] = 12'h100 + 12'(c); layer_en = 6'b000001; pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0; layer_en = '0;
            end
            tick();
            if (c >= 1 && c <= 8) begin
                check($sformatf("stream_valid_%0d", c - 1), rgb_valid, 1);
                check($sformatf("stream_rgb_%0d", c - 1), rgb_out, 12'h100 + 12'(c - 1));
            end else begin
                check($sformatf("stream_idle_%0d", c), rgb_valid, 0);
            end
        end

        // Streaming with Reset after the third strobe
        for (int c = 0; c < 3; c++) begin
            lay[0] = 12'h200 + 12'(c); layer_en = 6'b000001; pix_valid = 1'b1;
            tick();
            if (c >= 1) check($sformatf("rs_rgb_%0d", c - 1), rgb_out, 12'h200 + 12'(c - 1));
        end
        Reset = 1'b1;
        #1;
        check("rs_async_rgb_out", rgb_out, 0);
        check("rs_async_collision", collision, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rs_hold_valid_%0d", c), rgb_valid, 0);
        end
        check("rs_active_mask", dut.active_mask_reg, 6'h3F);
        check("rs_pending_mask", dut.pending_mask_reg, 6'h3F);
        check("rs_cv", collision_valid, 0);
        pix_valid = 1'b0; layer_en = '0;
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rs_post_idle_%0d", c), rgb_valid, 0);
        end
        check("rs_post_rgb_out", rgb_out, 0);
        lay[0] = 12'hABC;
        run_pixel("post_reset_pixel", 6'b000001, 1'b1, 1'b0, 12'hABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
